// File: rtl/db9_multipad_scanner.sv
// Megadrive DB9 scanner for NUM_PORTS pads, with 3/6-button auto-detect. `define DB9_SPLITTER_EN to read one DB9 through a splitter.
// Latency: one scan, (8+FRAME_GAP)*TICK_DIV cycles after a 2-FF input sync; no backpressure, outputs hold between frame_done pulses.
module db9_multipad_scanner #(
  parameter int NUM_PORTS = 2,
  parameter int TICK_DIV  = 480,
  parameter int FRAME_GAP = 200
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [NUM_PORTS*6-1:0]  db9_in,
  output logic                    db9_select,
  output logic [1:0]              port_sel,
  output logic [NUM_PORTS*12-1:0] joy_out,
  output logic [NUM_PORTS-1:0]    pad_present,
  output logic [NUM_PORTS-1:0]    six_btn,
  output logic                    frame_done
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW = $clog2(FRAME_GAP + 1);

`ifdef DB9_SPLITTER_EN
  localparam int SW = 6;
  logic unused_pins;
  assign unused_pins = ^db9_in;
`else
  localparam int SW = NUM_PORTS * 6;
`endif

  logic [SW-1:0] db9_s1, db9_s2;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      db9_s1 <= '1;
      db9_s2 <= '1;
    end else begin
      db9_s1 <= db9_in[SW-1:0];
      db9_s2 <= db9_s1;
    end
  end

  logic [PW-1:0] presc_q;
  logic          tick;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) presc_q <= '0;
    else          presc_q <= tick ? '0 : presc_q + 1'b1;
  end

  typedef enum logic {S_GAP, S_SCAN} state_t;
  state_t        state_q, state_d;
  logic [2:0]    phase_q, phase_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          commit;
  logic          samp;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_GAP;
      phase_q <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      gap_q   <= gap_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    gap_d   = gap_q;
    commit  = 1'b0;
    if (tick) begin
      case (state_q)
        S_GAP: begin
          if (gap_q == GW'(FRAME_GAP - 1)) begin
            state_d = S_SCAN;
            phase_d = '0;
            gap_d   = '0;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        S_SCAN: begin
          if (phase_q == 3'd7) begin
            commit  = 1'b1;
            state_d = S_GAP;
            gap_d   = '0;
          end else begin
            phase_d = phase_q + 3'd1;
          end
        end
        default: state_d = S_GAP;
      endcase
    end
  end

  assign db9_select = (state_q == S_GAP) || !phase_q[0];
  assign samp       = tick && (state_q == S_SCAN);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) frame_done <= 1'b0;
    else          frame_done <= commit;
  end

`ifdef DB9_SPLITTER_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)    port_sel <= 2'd0;
    else if (commit) port_sel <= (port_sel == 2'(NUM_PORTS - 1)) ? 2'd0 : port_sel + 2'd1;
  end
`else
  assign port_sel = 2'd0;
`endif

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [5:0]  pin;
    logic        en;
    // cap_q holds raw active-low pins already placed in joy_out bit order
    logic [11:0] cap_q, joy_q;
    logic        pres_q, six_q, pres_out_q, six_out_q;

`ifdef DB9_SPLITTER_EN
    assign pin = db9_s2;
    assign en  = (port_sel == 2'(k));
`else
    assign pin = db9_s2[6*k +: 6];
    assign en  = 1'b1;
`endif

    always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
        cap_q      <= '1;
        pres_q     <= 1'b0;
        six_q      <= 1'b0;
        joy_q      <= '0;
        pres_out_q <= 1'b0;
        six_out_q  <= 1'b0;
      end else if (en && samp) begin
        case (phase_q)
          3'd0: cap_q[5:0] <= {pin[5], pin[4], pin[0], pin[1], pin[2], pin[3]};
          3'd1: begin
            pres_q     <= ~pin[1] & ~pin[0];
            cap_q[7:6] <= {pin[5], pin[4]};
          end
          3'd5: six_q <= pres_q & (pin[3:0] == 4'b0000);
          3'd6: if (six_q) cap_q[11:8] <= {pin[0], pin[1], pin[2], pin[3]};
          3'd7: begin
            joy_q      <= pres_q ? {(six_q ? ~cap_q[11:8] : 4'h0), ~cap_q[7:0]} : 12'h000;
            pres_out_q <= pres_q;
            six_out_q  <= pres_q & six_q;
          end
          default: ;
        endcase
      end
    end

    assign joy_out[12*k +: 12] = joy_q;
    assign pad_present[k]      = pres_out_q;
    assign six_btn[k]          = six_out_q;
  end

endmodule

// File: tb/tb_db9_multipad_scanner.sv
// Directed bench for db9_multipad_scanner with behavioural 3/6-button pad models on a short phase timer.
`timescale 1ns/1ps
module tb_db9_multipad_scanner;
  localparam int NP = 2;
  localparam int TD = 4;
  localparam int FG = 2;

  logic            clk_sys = 1'b0;
  logic            reset_n = 1'b0;
  logic [NP*6-1:0] db9_in;
  logic            db9_select;
  logic [1:0]      port_sel;
  logic [NP*12-1:0] joy_out;
  logic [NP-1:0]   pad_present;
  logic [NP-1:0]   six_btn;
  logic            frame_done;

  int total = 0;
  int bad   = 0;

  logic [11:0] pad_btn [NP];
  int          pad_kind [NP];   // 0 absent, 1 three-button, 2 six-button
  int          lows     = 0;
  int          hi_cnt   = 0;
  logic        sel_prev = 1'b1;

  db9_multipad_scanner #(.NUM_PORTS(NP), .TICK_DIV(TD), .FRAME_GAP(FG)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .db9_in(db9_in), .db9_select(db9_select),
    .port_sel(port_sel), .joy_out(joy_out), .pad_present(pad_present),
    .six_btn(six_btn), .frame_done(frame_done)
  );

  always #5 clk_sys = ~clk_sys;

  function automatic logic [5:0] pad_pins(input logic [11:0] b, input int kind, input logic sel, input int n);
    logic [5:0] p;
    if (kind == 0) p = 6'h3F;
    else if (sel) begin
      if (kind == 2 && n == 3) p = ~{b[5], b[4], b[8], b[9], b[10], b[11]};
      else                     p = ~{b[5], b[4], b[0], b[1], b[2], b[3]};
    end else begin
      if (kind == 2 && n == 3)      p = {~b[7], ~b[6], 4'b0000};
      else if (kind == 2 && n == 4) p = {~b[7], ~b[6], 4'b1111};
      else                          p = {~b[7], ~b[6], ~b[0], ~b[1], 2'b00};
    end
    return p;
  endfunction

  // Pads count SELECT falling edges and time out after a long high period
  always @(negedge clk_sys) begin
    if (db9_select) begin
      hi_cnt = hi_cnt + 1;
      if (hi_cnt >= 6) lows = 0;
    end else begin
      if (sel_prev) lows = lows + 1;
      hi_cnt = 0;
    end
    sel_prev = db9_select;
  end

  always_comb begin
    db9_in = '1;
`ifdef DB9_SPLITTER_EN
    db9_in[5:0] = pad_pins(pad_btn[int'(port_sel) % NP], pad_kind[int'(port_sel) % NP], db9_select, lows);
`else
    for (int k = 0; k < NP; k++)
      db9_in[6*k +: 6] = pad_pins(pad_btn[k], pad_kind[k], db9_select, lows);
`endif
  end

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_sys); #1;
      if (frame_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_two(output bit ok);
    bit ok1, ok2;
    wait_frame(ok1);
    wait_frame(ok2);
    ok = ok1 && ok2;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clk_sys);
    #1;
    total++; if (db9_select !== 1'b1) begin bad++; $display("FAIL reset_select: got %b want 1", db9_select); end
    total++; if (port_sel !== 2'd0) begin bad++; $display("FAIL reset_port_sel: got %0d want 0", port_sel); end
    total++; if (joy_out !== '0) begin bad++; $display("FAIL reset_joy: got %h want 0", joy_out); end
    total++; if (pad_present !== '0) begin bad++; $display("FAIL reset_present: got %b want 0", pad_present); end
    total++; if (six_btn !== '0) begin bad++; $display("FAIL reset_six: got %b want 0", six_btn); end
    total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    @(negedge clk_sys);
    reset_n = 1'b1;
  endtask

`ifndef DB9_SPLITTER_EN
  task automatic test_three_btn;
    bit ok;
    pad_kind[0] = 1; pad_btn[0] = 12'h048;   // A + Right
    pad_kind[1] = 0; pad_btn[1] = 12'h000;
    wait_two(ok);
    total++; if (!ok) begin bad++; $display("FAIL three_wait: got timeout want frame_done"); end
    total++; if (joy_out[11:0] !== 12'h048) begin bad++; $display("FAIL three_a_right: got %h want 048", joy_out[11:0]); end
    total++; if (pad_present[0] !== 1'b1) begin bad++; $display("FAIL three_present: got %b want 1", pad_present[0]); end
    total++; if (six_btn[0] !== 1'b0) begin bad++; $display("FAIL three_six: got %b want 0", six_btn[0]); end
    total++; if (joy_out[23:12] !== 12'h000 || pad_present[1] !== 1'b0) begin
      bad++; $display("FAIL absent_port1: got joy=%h pres=%b want 000/0", joy_out[23:12], pad_present[1]);
    end
    pad_btn[0] = 12'h041;                    // A + Up
    wait_two(ok);
    total++; if (joy_out[11:0] !== 12'h041) begin bad++; $display("FAIL three_a_up: got %h want 041", joy_out[11:0]); end
  endtask

  task automatic test_six_btn;
    bit ok;
    pad_kind[1] = 2; pad_btn[1] = 12'h901;   // Mode + Z + Up
    wait_two(ok);
    total++; if (!ok) begin bad++; $display("FAIL six_wait: got timeout want frame_done"); end
    total++; if (joy_out[23:12] !== 12'h901) begin bad++; $display("FAIL six_mzu: got %h want 901", joy_out[23:12]); end
    total++; if (six_btn[1] !== 1'b1 || pad_present[1] !== 1'b1) begin
      bad++; $display("FAIL six_flags: got six=%b pres=%b want 1/1", six_btn[1], pad_present[1]);
    end
    total++; if (joy_out[11:0] !== 12'h041 || six_btn[0] !== 1'b0) begin
      bad++; $display("FAIL six_parallel_port0: got %h six=%b want 041/0", joy_out[11:0], six_btn[0]);
    end
    pad_btn[1] = 12'hCF0;                    // M X S A C B
    wait_two(ok);
    total++; if (joy_out[23:12] !== 12'hCF0) begin bad++; $display("FAIL six_mix: got %h want cf0", joy_out[23:12]); end
    pad_btn[1] = 12'h000;
    wait_two(ok);
    total++; if (joy_out[23:12] !== 12'h000 || six_btn[1] !== 1'b1) begin
      bad++; $display("FAIL six_idle: got %h six=%b want 000/1", joy_out[23:12], six_btn[1]);
    end
  endtask

  task automatic test_hold;
    bit ok, moved;
    moved = 1'b0;
    ok    = 1'b0;
    wait_frame(ok);
    pad_btn[0] = 12'h010;                    // B
    for (int i = 0; i < 200; i++) begin
      @(posedge clk_sys); #1;
      if (frame_done) begin ok = 1'b1; break; end
      if (joy_out[11:0] !== 12'h041) moved = 1'b1;
    end
    total++; if (moved || !ok) begin bad++; $display("FAIL hold_between_commits: got moved=%b done=%b want 0/1", moved, ok); end
    total++; if (joy_out[11:0] !== 12'h010) begin bad++; $display("FAIL hold_new_value: got %h want 010", joy_out[11:0]); end
  endtask

  task automatic test_no_pad;
    bit ok;
    pad_kind[0] = 0;
    wait_two(ok);
    total++; if (joy_out[11:0] !== 12'h000 || pad_present[0] !== 1'b0) begin
      bad++; $display("FAIL no_pad: got %h pres=%b want 000/0", joy_out[11:0], pad_present[0]);
    end
    wait_frame(ok);
    repeat (20) @(posedge clk_sys);
    pad_kind[0] = 1; pad_btn[0] = 12'h020;   // hot-plug mid-scan, C held
    wait_two(ok);
    total++; if (!ok || joy_out[11:0] !== 12'h020 || pad_present[0] !== 1'b1) begin
      bad++; $display("FAIL hotplug: got %h pres=%b want 020/1", joy_out[11:0], pad_present[0]);
    end
  endtask
`else
  task automatic test_splitter;
    bit          ok, sel_moved;
    logic [1:0]  exp_sel  [3] = '{2'd1, 2'd0, 2'd1};
    logic [11:0] exp_j0   [3] = '{12'h041, 12'h041, 12'h010};
    logic [11:0] exp_j1   [3] = '{12'h000, 12'h901, 12'h901};
    logic [1:0]  cur_sel;
    pad_kind[0] = 1; pad_btn[0] = 12'h041;
    pad_kind[1] = 2; pad_btn[1] = 12'h901;
    reset_n = 1'b0;
    repeat (2) @(posedge clk_sys);
    @(negedge clk_sys);
    reset_n = 1'b1;
    cur_sel = 2'd0;
    for (int f = 0; f < 3; f++) begin
      sel_moved = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk_sys); #1;
        if (frame_done) begin ok = 1'b1; break; end
        if (port_sel !== cur_sel) sel_moved = 1'b1;
      end
      total++; if (!ok || sel_moved) begin bad++; $display("FAIL split_sel_stable[%0d]: got moved=%b done=%b want 0/1", f, sel_moved, ok); end
      total++; if (port_sel !== exp_sel[f]) begin bad++; $display("FAIL split_port_sel[%0d]: got %0d want %0d", f, port_sel, exp_sel[f]); end
      total++; if (joy_out[11:0] !== exp_j0[f]) begin bad++; $display("FAIL split_joy0[%0d]: got %h want %h", f, joy_out[11:0], exp_j0[f]); end
      total++; if (joy_out[23:12] !== exp_j1[f]) begin bad++; $display("FAIL split_joy1[%0d]: got %h want %h", f, joy_out[23:12], exp_j1[f]); end
      cur_sel = exp_sel[f];
      if (f == 1) pad_btn[0] = 12'h010;
    end
  endtask
`endif

  task automatic test_mid_reset;
    int n;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_sys);
      if (!db9_select) begin found = 1'b1; break; end
    end
    total++; if (!found) begin bad++; $display("FAIL mid_reset_find_low: got timeout want select=0"); end
    reset_n = 1'b0;
    #1;
    total++; if (db9_select !== 1'b1) begin bad++; $display("FAIL mid_reset_select: got %b want 1", db9_select); end
    total++; if (joy_out !== '0 || pad_present !== '0 || six_btn !== '0) begin
      bad++; $display("FAIL mid_reset_outputs: got joy=%h pres=%b six=%b want 0", joy_out, pad_present, six_btn);
    end
    total++; if (frame_done !== 1'b0 || port_sel !== 2'd0) begin
      bad++; $display("FAIL mid_reset_ctrl: got fd=%b sel=%0d want 0/0", frame_done, port_sel);
    end
    repeat (2) @(negedge clk_sys);
    reset_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_sys); #1;
      n++;
      if (!db9_select) break;
    end
    total++; if (n != (FG + 1) * TD) begin bad++; $display("FAIL first_fall: got %0d cycles want %0d", n, (FG + 1) * TD); end
  endtask

  task automatic test_timing;
    bit   ok;
    int   edges[$];
    int   fd_cnt, fd_t;
    logic prev;
    wait_frame(ok);
    total++; if (!ok) begin bad++; $display("FAIL timing_wait: got timeout want frame_done"); end
    prev   = db9_select;
    fd_cnt = 0;
    fd_t   = -1;
    for (int t = 1; t <= 41; t++) begin
      @(posedge clk_sys); #1;
      if (db9_select !== prev) edges.push_back(t);
      prev = db9_select;
      if (frame_done) begin fd_cnt++; fd_t = t; end
    end
    total++; if (edges.size() != 8) begin bad++; $display("FAIL timing_edge_count: got %0d want 8", edges.size()); end
    else begin
      total++; if (edges[0] != (FG + 1) * TD) begin bad++; $display("FAIL gap_high_time: got %0d want %0d", edges[0], (FG + 1) * TD); end
      for (int i = 1; i < 8; i++) begin
        total++;
        if (edges[i] - edges[i-1] != TD) begin bad++; $display("FAIL scan_edge_gap[%0d]: got %0d want %0d", i, edges[i] - edges[i-1], TD); end
      end
    end
    total++; if (fd_cnt != 1 || fd_t != 40) begin bad++; $display("FAIL frame_done_width: got count=%0d at=%0d want 1 at 40", fd_cnt, fd_t); end
  endtask

  initial begin
    for (int k = 0; k < NP; k++) begin
      pad_kind[k] = 0;
      pad_btn[k]  = 12'h000;
    end
    test_reset;
`ifdef DB9_SPLITTER_EN
    test_splitter;
`else
    test_three_btn;
    test_six_btn;
    test_hold;
    test_no_pad;
`endif
    test_mid_reset;
    test_timing;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
